// File: rtl/inst_seq_driver.sv
// Programmable instruction sequencer: presents a loadable program buffer to the core's
// Instruction input with per-entry hold time, run/stop control, looping and an issue counter.
module inst_seq_driver #(
   parameter int          XLEN     = 32,
   parameter int          DEPTH    = 16,
   parameter int          AW       = $clog2(DEPTH),
   parameter int          HOLD_W   = 8,
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [XLEN-1:0]   wr_inst,
   input  logic [HOLD_W-1:0] wr_hold,
   input  logic [AW:0]       prog_len,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [XLEN-1:0]   Instruction,
   output logic              inst_valid,
   output logic [AW-1:0]     cur_idx,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  issued_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [XLEN-1:0]   inst_mem [DEPTH];
   logic [HOLD_W-1:0] hold_mem [DEPTH];
   logic [HOLD_W-1:0] hold_cnt;
   logic [AW-1:0]     last_idx;
   logic              loop_q;

   logic [AW:0]       len_clamped;
   logic              start_acc;
   logic              advance;
   logic              is_last;
   logic              wr_acc;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      len_clamped = prog_len;
      start_acc   = 1'b0;
      advance     = 1'b0;
      is_last     = (cur_idx == last_idx);
      wr_acc      = wr_en && (state != ISSUE);

      if (prog_len > (AW+1)'(DEPTH))
         len_clamped = (AW+1)'(DEPTH);

      case (state)
         IDLE, DONE: begin
            if (stop) begin
               state_next = IDLE;
            end else if (start) begin
               start_acc  = 1'b1;
               state_next = (len_clamped != '0) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if (stop) begin
               state_next = IDLE;
            end else if (hold_cnt == '0) begin
               advance = 1'b1;
               if (is_last && !loop_q)
                  state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_idx    <= '0;
         hold_cnt   <= '0;
         issued_cnt <= '0;
         last_idx   <= '0;
         loop_q     <= 1'b0;
      end else if (start_acc) begin
         cur_idx    <= '0;
         issued_cnt <= '0;
         if (len_clamped != '0) begin
            hold_cnt <= hold_mem[0];
            last_idx <= AW'(len_clamped - (AW+1)'(1));
            loop_q   <= loop_en;
         end
      end else if (state == ISSUE && !stop) begin
         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end else begin
            if (issued_cnt != '1)
               issued_cnt <= issued_cnt + CNT_W'(1);
            if (!is_last) begin
               cur_idx  <= cur_idx + AW'(1);
               hold_cnt <= hold_mem[cur_idx + AW'(1)];
            end else if (loop_q) begin
               cur_idx  <= '0;
               hold_cnt <= hold_mem[0];
            end
         end
      end
   end

   // NOTE: the program buffer is reset on purpose: every entry must read as a NOP with zero hold after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem[i] <= XLEN'(NOP_INST);
            hold_mem[i] <= '0;
         end
      end else if (wr_acc) begin
         inst_mem[wr_addr] <= wr_inst;
         hold_mem[wr_addr] <= wr_hold;
      end
   end

   assign busy        = (state == ISSUE);
   assign done        = (state == DONE);
   assign inst_valid  = busy;
   assign Instruction = busy ? inst_mem[cur_idx] : XLEN'(NOP_INST);

endmodule

// File: tb/tb_inst_seq_driver.sv
// Directed self-checking bench for inst_seq_driver: inputs change 1 ns after the rising
// edge and outputs are sampled at that same settled point.
module tb_inst_seq_driver;

   localparam int          XLEN   = 32;
   localparam int          DEPTH  = 16;
   localparam int          AW     = 4;
   localparam int          HOLD_W = 8;
   localparam int          CNT_W  = 16;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [XLEN-1:0]   wr_inst;
   logic [HOLD_W-1:0] wr_hold;
   logic [AW:0]       prog_len;
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [XLEN-1:0]   Instruction;
   logic              inst_valid;
   logic [AW-1:0]     cur_idx;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  issued_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   inst_seq_driver dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_inst     (wr_inst),
      .wr_hold     (wr_hold),
      .prog_len    (prog_len),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .Instruction (Instruction),
      .inst_valid  (inst_valid),
      .cur_idx     (cur_idx),
      .busy        (busy),
      .done        (done),
      .issued_cnt  (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic [HOLD_W-1:0] h);
      wr_en = 1'b1; wr_addr = a; wr_inst = d; wr_hold = h;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW:0] len, input logic lp);
      prog_len = len; loop_en = lp; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_inst = '0; wr_hold = '0;
      prog_len = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      #12;
      check("rst_inst",   Instruction, NOP);
      check("rst_valid",  32'(inst_valid), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_cnt",    32'(issued_cnt), 32'd0);
      check("rst_idx",    32'(cur_idx), 32'd0);
      @(negedge clk); reset = 1'b0;
      tick();

      // Three-entry program, hold 0
      write_entry(4'd0, 32'hFFFFF137, 8'd0);
      write_entry(4'd1, 32'hFFFFE0B7, 8'd0);
      write_entry(4'd2, 32'h00110233, 8'd0);
      pulse_start(5'd3, 1'b0);
      check("p3_c1_inst",  Instruction, 32'hFFFFF137);
      check("p3_c1_valid", 32'(inst_valid), 32'd1);
      check("p3_c1_idx",   32'(cur_idx), 32'd0);
      tick();
      check("p3_c2_inst",  Instruction, 32'hFFFFE0B7);
      check("p3_c2_idx",   32'(cur_idx), 32'd1);
      tick();
      check("p3_c3_inst",  Instruction, 32'h00110233);
      tick();
      check("p3_c4_inst",  Instruction, NOP);
      check("p3_c4_valid", 32'(inst_valid), 32'd0);
      check("p3_c4_done",  32'(done), 32'd1);
      check("p3_c4_cnt",   32'(issued_cnt), 32'd3);

      // Hold time: entry0 hold 3 -> 4 cycles, entry1 hold 0 -> 1 cycle
      write_entry(4'd0, 32'hFFFFF137, 8'd3);
      pulse_start(5'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("hold_e0_c%0d", k), Instruction, 32'hFFFFF137);
         tick();
      end
      check("hold_e1_inst", Instruction, 32'hFFFFE0B7);
      check("hold_e1_idx",  32'(cur_idx), 32'd1);
      tick();
      check("hold_done",    32'(done), 32'd1);
      check("hold_cnt",     32'(issued_cnt), 32'd2);

      // Looping, plus write and start attempted during ISSUE
      write_entry(4'd0, 32'hFFFFF137, 8'd0);
      pulse_start(5'd2, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         check($sformatf("loop_idx_%0d", k), 32'(cur_idx), 32'((k - 1) % 2));
         check($sformatf("loop_inst_%0d", k), Instruction,
               ((k - 1) % 2 == 0) ? 32'hFFFFF137 : 32'hFFFFE0B7);
         if (k == 3) begin
            wr_en = 1'b1; wr_addr = 4'd1; wr_inst = 32'hDEADBEEF; wr_hold = 8'd5;
            start = 1'b1; prog_len = 5'd3; loop_en = 1'b0;
         end else begin
            wr_en = 1'b0; start = 1'b0;
         end
         tick();
      end
      check("loop_cnt10", 32'(issued_cnt), 32'd10);
      check("loop_busy",  32'(busy), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_inst",  Instruction, NOP);
      check("stop_valid", 32'(inst_valid), 32'd0);
      check("stop_busy",  32'(busy), 32'd0);
      check("stop_done",  32'(done), 32'd0);
      check("stop_cnt",   32'(issued_cnt), 32'd10);
      tick();
      check("stop_cnt2",  32'(issued_cnt), 32'd10);

      // prog_len = 0 goes straight to DONE
      pulse_start(5'd0, 1'b0);
      check("len0_done",  32'(done), 32'd1);
      check("len0_valid", 32'(inst_valid), 32'd0);
      check("len0_cnt",   32'(issued_cnt), 32'd0);

      // prog_len = DEPTH+1 clamps to DEPTH; restart directly from DONE
      pulse_start(5'd17, 1'b0);
      n = 0;
      while (inst_valid && n < 40) begin
         if (n == 1) check("clamp_e1_inst", Instruction, 32'hFFFFE0B7);
         n++;
         tick();
      end
      check("clamp_cycles", n, 32'd16);
      check("clamp_done",   32'(done), 32'd1);
      check("clamp_cnt",    32'(issued_cnt), 32'd16);

      // stop from DONE, then start+stop together from IDLE
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("done_stop_done", 32'(done), 32'd0);
      check("done_stop_busy", 32'(busy), 32'd0);
      prog_len = 5'd3; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("ss_busy",  32'(busy), 32'd0);
      check("ss_done",  32'(done), 32'd0);
      check("ss_valid", 32'(inst_valid), 32'd0);

      // Asynchronous reset mid-run
      pulse_start(5'd3, 1'b0);
      check("mid_valid_pre", 32'(inst_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_inst",  Instruction, NOP);
      check("mid_valid", 32'(inst_valid), 32'd0);
      check("mid_busy",  32'(busy), 32'd0);
      check("mid_cnt",   32'(issued_cnt), 32'd0);
      #1 reset = 1'b0;
      tick();
      pulse_start(5'd1, 1'b0);
      check("post_rst_valid", 32'(inst_valid), 32'd1);
      check("post_rst_e0",    Instruction, NOP);
      tick();
      check("post_rst_done",  32'(done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1);
   end

endmodule
